// File: rtl/wb_ack_hold_pkg.sv
// Shared definitions for wb_ack_hold: FSM state encoding, the request payload
// captured toward the peripheral, and the default error read data.
package wb_ack_hold_pkg;

    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    localparam logic [DAT_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Write-side payload forwarded to the peripheral alongside the address.
    typedef struct packed {
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic             we;
    } per_pay_t;

endpackage

// File: rtl/wb_ack_hold.sv
// wb_ack_hold: turns the CDC's level-held Wishbone request into a one-cycle
// peripheral request, then holds ack/read data until cyc&stb falls.
// A response timeout returns ERR_DATA and sets a sticky flag.
// Ports:
//   clk, rst              clock, async active-high reset
//   wbs_*_i / wbs_*_o     Wishbone slave side (from/to CDC)
//   per_*_o / per_*_i     local peripheral bus (registered request, 1-cycle ack)
//   timeout_o             sticky timeout flag, cleared by timeout_clr_i
module wb_ack_hold
    import wb_ack_hold_pkg::*;
#(
    parameter int unsigned      AW       = 32,
    parameter int unsigned      TIMEOUT  = 255,
    parameter logic [DAT_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    wbs_adr_i,
    input  logic [DAT_W-1:0] wbs_dat_i,
    input  logic [SEL_W-1:0] wbs_sel_i,
    input  logic             wbs_we_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    output logic [DAT_W-1:0] wbs_dat_o,
    output logic             wbs_ack_o,
    output logic [AW-1:0]    per_adr_o,
    output logic [DAT_W-1:0] per_dat_o,
    output logic [SEL_W-1:0] per_sel_o,
    output logic             per_we_o,
    output logic             per_req_o,
    input  logic [DAT_W-1:0] per_dat_i,
    input  logic             per_ack_i,
    output logic             timeout_o,
    input  logic             timeout_clr_i
);

    localparam int unsigned CLOG_W = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      per_adr_q, per_adr_d;
    per_pay_t           per_pay_q, per_pay_d;
    logic               per_req_q, per_req_d;
    logic               ack_q, ack_d;
    logic [DAT_W-1:0]   rdat_q, rdat_d;
    logic               tout_q, tout_d;

    logic               cs;
    logic               expired;
    logic               tout_set;
    logic [CNT_W-1:0]   cnt_inc;

    assign cs      = wbs_cyc_i & wbs_stb_i;
    // >= rather than == so an entry into DRAIN at the last count still expires.
    assign expired = (cnt_q >= CNT_LAST);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            per_adr_q <= '0;
            per_pay_q <= '0;
            per_req_q <= 1'b0;
            ack_q     <= 1'b0;
            rdat_q    <= '0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_adr_q <= per_adr_d;
            per_pay_q <= per_pay_d;
            per_req_q <= per_req_d;
            ack_q     <= ack_d;
            rdat_q    <= rdat_d;
            tout_q    <= tout_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_adr_d = per_adr_q;
        per_pay_d = per_pay_q;
        per_req_d = 1'b0;
        ack_d     = ack_q;
        rdat_d    = rdat_q;
        tout_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs) begin
                    per_adr_d     = wbs_adr_i;
                    per_pay_d.dat = wbs_dat_i;
                    per_pay_d.sel = wbs_sel_i;
                    per_pay_d.we  = wbs_we_i;
                    per_req_d     = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (!cs) begin
                    // Abort: an ack in the same cycle ends the transfer outright.
                    state_d = per_ack_i ? ST_IDLE : ST_DRAIN;
                end else if (per_ack_i) begin
                    rdat_d  = per_dat_i;
                    ack_d   = 1'b1;
                    state_d = ST_HOLD;
                end else if (expired) begin
                    rdat_d   = ERR_DATA;
                    ack_d    = 1'b1;
                    tout_set = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!cs) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_inc;
                if (per_ack_i) begin
                    state_d = ST_IDLE;
                end else if (expired) begin
                    tout_set = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new timeout beats a simultaneous clear.
        tout_d = tout_set | (tout_q & ~timeout_clr_i);
    end

    assign wbs_dat_o = rdat_q;
    assign wbs_ack_o = ack_q;
    assign per_adr_o = per_adr_q;
    assign per_dat_o = per_pay_q.dat;
    assign per_sel_o = per_pay_q.sel;
    assign per_we_o  = per_pay_q.we;
    assign per_req_o = per_req_q;
    assign timeout_o = tout_q;

endmodule

// File: doc/wb_ack_hold.md
Name: wb_ack_hold

Overview:
- Slave-domain stage directly downstream of the Wishbone clock-domain-crossing block; consumes its cyc/stb/adr/dat/sel/we outputs.
- Converts the CDC's level-held request into a single-cycle request pulse to a local peripheral bus. Captures the peripheral's one-cycle ack and read data, then holds ack and data stable until the CDC drops cyc/stb.
- Adds a response timeout so a dead peripheral cannot hang the master domain.

Parameters:
- AW, 32, address width.
- TIMEOUT, 255, maximum cycles to wait for per_ack_i after per_req_o; must be at least 2.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  slave-domain clock.
- rst  in  1  reset, asynchronous, active-high.
- wbs_adr_i  in  AW  address from CDC; stable while cyc&stb is high.
- wbs_dat_i  in  32  write data from CDC.
- wbs_sel_i  in  4  byte selects.
- wbs_we_i  in  1  write enable.
- wbs_cyc_i  in  1  cycle.
- wbs_stb_i  in  1  strobe.
- wbs_dat_o  out  32  read data to CDC; held while wbs_ack_o is high.
- wbs_ack_o  out  1  level ack; held until cyc&stb falls.
- per_adr_o  out  AW  registered address to peripheral.
- per_dat_o  out  32  registered write data.
- per_sel_o  out  4  registered byte selects.
- per_we_o  out  1  registered write enable.
- per_req_o  out  1  one-cycle request pulse.
- per_dat_i  in  32  peripheral read data; valid when per_ack_i is high.
- per_ack_i  in  1  one-cycle peripheral ack; may arrive 1..N cycles after per_req_o.
- timeout_o  out  1  sticky timeout flag.
- timeout_clr_i  in  1  clears timeout_o.

Behaviour:
- cs = wbs_cyc_i & wbs_stb_i. Inputs already pass through the CDC synchronizer; no further sync is applied.
- Reset: state IDLE; all outputs and internal registers 0, including wbs_dat_o, per_* and timeout_o.
- IDLE: if cs is high, capture adr/dat/sel/we into per_* registers, assert per_req_o the next cycle, go to WAIT and load the counter with 0.
- WAIT:
  - per_req_o is low (the pulse lasts exactly 1 cycle); counter increments each cycle.
  - If per_ack_i: latch per_dat_i into wbs_dat_o (writes latch it too; the value is don't-care to the master), assert wbs_ack_o, go to HOLD.
  - If the counter reaches TIMEOUT-1 with no ack: wbs_dat_o = ERR_DATA, wbs_ack_o = 1, timeout_o = 1, go to HOLD.
  - If cs falls (master abort or CDC reset) before ack: go to DRAIN; wbs_ack_o stays 0.
- HOLD: wbs_ack_o = 1 and wbs_dat_o frozen while cs is high. When cs falls: wbs_ack_o = 0 the same-edge registered, go to IDLE. Minimum one IDLE cycle between transactions.
- DRAIN: wait for per_ack_i or timeout (counter keeps running); discard data and do not set wbs_ack_o. timeout_o is set if the drain times out. Then go to IDLE. A new cs in DRAIN is not accepted until back in IDLE.
- Counter: 8 bits wide minimum, clog2(TIMEOUT+1) bits in general; saturates and never wraps.
- per_ack_i outside WAIT/DRAIN: ignored.
- per_ack_i in the same cycle as the timeout: ack wins, real data is returned, no timeout flag.
- per_ack_i in the same cycle as cs falling in WAIT: go to IDLE directly; wbs_ack_o is not asserted.
- timeout_clr_i in the same cycle as a new timeout: set wins.
- Latency: cs seen to per_req_o = 1 cycle; per_ack_i to wbs_ack_o = 1 cycle; cs fall to wbs_ack_o low = 1 cycle.
- Async reset mid-operation: immediately returns to IDLE with outputs 0. An outstanding peripheral ack arriving after reset is ignored in IDLE.

Decomposition:
- Shared package: state encoding (IDLE, WAIT, HOLD, DRAIN as a 2-bit enum) and the default ERR_DATA constant.
- No sub-module needed; optional wb_timeout_cnt (load/inc/saturate/expire) if reused elsewhere.

Test Plan:
- Read, ack after 3 cycles, per_dat_i=32'h1234_5678: per_req_o pulses once, per_adr_o matches wbs_adr_i, wbs_ack_o rises 1 cycle after ack with wbs_dat_o=32'h1234_5678, and holds until cs drops.
- Write adr=0x10, dat=0xA5A5_A5A5, sel=4'b0011: per_we_o=1, per_sel_o=4'b0011, per_dat_o=0xA5A5_A5A5; ack handshake completes, timeout_o stays 0.
- No peripheral ack, TIMEOUT=8: wbs_ack_o rises 8 cycles after per_req_o with wbs_dat_o=32'hDEAD_BEEF and timeout_o=1; timeout_clr_i clears the flag.
- cs drops 2 cycles into WAIT, ack arrives 3 cycles later: no wbs_ack_o; the next transaction issued immediately waits until DRAIN exits, then gets a clean single per_req_o.
- per_ack_i coincident with the timeout cycle: real data returned, timeout_o=0.
- rst asserted in HOLD: wbs_ack_o=0 and wbs_dat_o=0 asynchronously; a stray per_ack_i afterwards has no effect.
